// File: rtl/id_decode_stage.sv
// id_decode_stage: registered MIPS instruction-decode stage between IF and EX.
// Decodes one instruction into one-hot control groups. Generates stalls for
// load-use hazards and for HI/LO access while a mult/div is still running.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready never depends on out_valid of a later stage combinationally
// beyond out_ready. out_valid/data hold steady while out_ready is low. flush
// forces in_ready high so IF can drop its instruction, and it empties the
// output register.
module id_decode_stage #(
    parameter int ALU_OPS     = 20,
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 33,
    parameter int LU_STALL_EN = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [31:0]        in_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [31:0]        out_pc,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_sa,
    output logic [15:0]        out_imm,
    output logic [25:0]        out_instIndex,
    output logic [4:0]         ctl_pcValue_mux,
    output logic [2:0]         ctl_aluSrc1_mux,
    output logic [3:0]         ctl_aluSrc2_mux,
    output logic [ALU_OPS-1:0] ctl_alu_mux,
    output logic [2:0]         ctl_rfWriteData_mux,
    output logic [2:0]         ctl_rfWriteAddr_mux,
    output logic               ctl_rf_wen,
    output logic               ctl_dataRam_en,
    output logic               ctl_dataRam_wen,
    output logic               ctl_low_wen,
    output logic               ctl_high_wen,
    output logic               ctl_temp_wen,
    output logic               hilo_busy,
    output logic [31:0]        stall_count
);
    localparam int HL_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int HL_W   = $clog2(HL_MAX + 1);

    logic [5:0]  op, funct;
    logic [4:0]  pc_d;
    logic [2:0]  src1_d, wd_d, wa_d;
    logic [3:0]  src2_d;
    logic [15:0] alu16_d;
    logic        rf_wen_d, ram_en_d, ram_wen_d, lo_wen_d, hi_wen_d, temp_wen_d;
    logic        alu_rr, alu_ri, is_store, is_mul, is_div, is_hl, reads_rt;

    assign op    = in_inst[31:26];
    assign funct = in_inst[5:0];

    // Group bit meaning:
    //   pcValue  : 0 pc+4, 1 branch, 2 jump target, 3 register target, 4 unused
    //   aluSrc1  : 0 rs, 1 shamt, 2 pc
    //   aluSrc2  : 0 rt, 1 sign-extended imm, 2 zero-extended imm, 3 HI/LO
    //   rfWData  : 0 ALU result, 1 data memory, 2 link address
    //   rfWAddr  : 0 rd, 1 rt, 2 $31
    // Instruction decode into the one-hot control groups.
    always_comb begin
        pc_d       = 5'b00001;
        src1_d     = 3'b000;
        src2_d     = 4'b0000;
        alu16_d    = 16'h0000;
        wd_d       = 3'b000;
        wa_d       = 3'b000;
        rf_wen_d   = 1'b0;
        ram_en_d   = 1'b0;
        ram_wen_d  = 1'b0;
        lo_wen_d   = 1'b0;
        hi_wen_d   = 1'b0;
        temp_wen_d = 1'b0;
        alu_rr     = 1'b0;
        alu_ri     = 1'b0;
        is_store   = 1'b0;
        is_mul     = 1'b0;
        is_div     = 1'b0;
        is_hl      = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00: begin alu16_d[8]  = 1'b1; src1_d = 3'b010; alu_rr = 1'b1; end
                    6'h02: begin alu16_d[9]  = 1'b1; src1_d = 3'b010; alu_rr = 1'b1; end
                    6'h03: begin alu16_d[10] = 1'b1; src1_d = 3'b010; alu_rr = 1'b1; end
                    6'h04: begin alu16_d[8]  = 1'b1; src1_d = 3'b001; alu_rr = 1'b1; end
                    6'h06: begin alu16_d[9]  = 1'b1; src1_d = 3'b001; alu_rr = 1'b1; end
                    6'h07: begin alu16_d[10] = 1'b1; src1_d = 3'b001; alu_rr = 1'b1; end
                    6'h08: pc_d = 5'b01000;
                    6'h09: begin
                        pc_d = 5'b01000; src1_d = 3'b100;
                        wd_d = 3'b100; wa_d = 3'b001; rf_wen_d = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        is_hl = 1'b1; src2_d = 4'b1000;
                        wd_d = 3'b001; wa_d = 3'b001; rf_wen_d = 1'b1;
                    end
                    6'h11: begin is_hl = 1'b1; src1_d = 3'b001; hi_wen_d = 1'b1; end
                    6'h13: begin is_hl = 1'b1; src1_d = 3'b001; lo_wen_d = 1'b1; end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        is_hl = 1'b1;
                        is_mul = ~funct[1];
                        is_div = funct[1];
                        alu16_d[12 + int'(funct[1:0])] = 1'b1;
                        src1_d = 3'b001; src2_d = 4'b0001;
                        lo_wen_d = 1'b1; hi_wen_d = 1'b1; temp_wen_d = 1'b1;
                    end
                    6'h20, 6'h21: begin alu16_d[0] = 1'b1; src1_d = 3'b001; alu_rr = 1'b1; end
                    6'h22, 6'h23: begin alu16_d[1] = 1'b1; src1_d = 3'b001; alu_rr = 1'b1; end
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        alu16_d[4 + int'(funct[1:0])] = 1'b1; src1_d = 3'b001; alu_rr = 1'b1;
                    end
                    6'h2a: begin alu16_d[2] = 1'b1; src1_d = 3'b001; alu_rr = 1'b1; end
                    6'h2b: begin alu16_d[3] = 1'b1; src1_d = 3'b001; alu_rr = 1'b1; end
                    default: ;
                endcase
            end
            6'h02: pc_d = 5'b00100;
            6'h03: begin
                pc_d = 5'b00100; src1_d = 3'b100;
                wd_d = 3'b100; wa_d = 3'b100; rf_wen_d = 1'b1;
            end
            6'h04, 6'h05: begin
                pc_d = 5'b00010; alu16_d[1] = 1'b1; src1_d = 3'b001; src2_d = 4'b0001;
            end
            6'h08, 6'h09: begin alu16_d[0] = 1'b1; src2_d = 4'b0010; alu_ri = 1'b1; end
            6'h0a: begin alu16_d[2] = 1'b1; src2_d = 4'b0010; alu_ri = 1'b1; end
            6'h0b: begin alu16_d[3] = 1'b1; src2_d = 4'b0010; alu_ri = 1'b1; end
            6'h0c: begin alu16_d[4] = 1'b1; src2_d = 4'b0100; alu_ri = 1'b1; end
            6'h0d: begin alu16_d[5] = 1'b1; src2_d = 4'b0100; alu_ri = 1'b1; end
            6'h0e: begin alu16_d[6] = 1'b1; src2_d = 4'b0100; alu_ri = 1'b1; end
            6'h0f: begin alu16_d[11] = 1'b1; src2_d = 4'b0100; alu_ri = 1'b1; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                alu16_d[0] = 1'b1; src1_d = 3'b001; src2_d = 4'b0010;
                wd_d = 3'b010; wa_d = 3'b010; rf_wen_d = 1'b1; ram_en_d = 1'b1;
            end
            6'h28, 6'h29, 6'h2b: begin
                is_store = 1'b1; alu16_d[0] = 1'b1; src1_d = 3'b001; src2_d = 4'b0010;
                ram_en_d = 1'b1; ram_wen_d = 1'b1;
            end
            default: ;
        endcase
        // Register-register ALU ops: rt operand, result to rd.
        if (alu_rr) begin
            src2_d = 4'b0001; wd_d = 3'b001; wa_d = 3'b001; rf_wen_d = 1'b1;
        end
        // Register-immediate ALU ops: rs operand, result to rt.
        if (alu_ri) begin
            src1_d = 3'b001; wd_d = 3'b001; wa_d = 3'b010; rf_wen_d = 1'b1;
        end
    end

    logic        out_valid_q, rf_wen_q, ram_en_q, ram_wen_q, lo_wen_q, hi_wen_q, temp_wen_q;
    logic [31:0] pc_q, sc_q, sc_d;
    logic [4:0]  rs_q, rt_q, rd_q, sa_q, pcm_q;
    logic [15:0] imm_q;
    logic [25:0] idx_q;
    logic [2:0]  src1_q, wd_q, wa_q;
    logic [3:0]  src2_q;
    logic [ALU_OPS-1:0] alu_q;
    logic [HL_W-1:0]    hl_cnt_q, hl_cnt_d;
    logic load, lu_hz, hl_hz, stall, accept;

    assign reads_rt = src2_d[0] | is_store;
    assign lu_hz    = (LU_STALL_EN != 0) && out_valid_q && wd_q[1] && (rt_q != 5'd0) &&
                      ((rt_q == in_inst[25:21]) || (reads_rt && (rt_q == in_inst[20:16])));
    assign hilo_busy = (hl_cnt_q != '0);
    assign hl_hz    = hilo_busy & is_hl;
    assign stall    = in_valid & (lu_hz | hl_hz);
    assign load     = ~out_valid_q | out_ready;
    assign in_ready = flush | (load & ~stall);
    assign accept   = in_valid & load & ~stall & ~flush;

    // HI/LO busy countdown: a new mult/div reloads, otherwise count down to zero.
    always_comb begin
        hl_cnt_d = hl_cnt_q;
        if (accept && is_mul)      hl_cnt_d = HL_W'(MUL_LAT);
        else if (accept && is_div) hl_cnt_d = HL_W'(DIV_LAT);
        else if (hilo_busy)        hl_cnt_d = hl_cnt_q - HL_W'(1);
    end

    // Saturating stall counter; flushed cycles are not counted.
    always_comb begin
        sc_d = sc_q;
        if (stall && !flush && (sc_q != 32'hFFFF_FFFF)) sc_d = sc_q + 32'd1;
    end

    // Output register: capture on load, flush empties it even under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            pc_q  <= '0; rs_q <= '0; rt_q <= '0; rd_q <= '0; sa_q <= '0;
            imm_q <= '0; idx_q <= '0; pcm_q <= '0; src1_q <= '0; src2_q <= '0;
            alu_q <= '0; wd_q <= '0; wa_q <= '0;
            rf_wen_q <= 1'b0; ram_en_q <= 1'b0; ram_wen_q <= 1'b0;
            lo_wen_q <= 1'b0; hi_wen_q <= 1'b0; temp_wen_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= in_valid & ~stall & ~flush;
            pc_q  <= in_pc;
            rs_q  <= in_inst[25:21]; rt_q <= in_inst[20:16];
            rd_q  <= in_inst[15:11]; sa_q <= in_inst[10:6];
            imm_q <= in_inst[15:0];  idx_q <= in_inst[25:0];
            pcm_q <= pc_d; src1_q <= src1_d; src2_q <= src2_d;
            alu_q <= ALU_OPS'(alu16_d); wd_q <= wd_d; wa_q <= wa_d;
            rf_wen_q <= rf_wen_d; ram_en_q <= ram_en_d; ram_wen_q <= ram_wen_d;
            lo_wen_q <= lo_wen_d; hi_wen_q <= hi_wen_d; temp_wen_q <= temp_wen_d;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end
    end

    // HI/LO countdown and stall counter state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hl_cnt_q <= '0;
            sc_q     <= '0;
        end else begin
            hl_cnt_q <= hl_cnt_d;
            sc_q     <= sc_d;
        end
    end

    assign out_valid           = out_valid_q;
    assign out_pc              = pc_q;
    assign out_rs              = rs_q;
    assign out_rt              = rt_q;
    assign out_rd              = rd_q;
    assign out_sa              = sa_q;
    assign out_imm             = imm_q;
    assign out_instIndex       = idx_q;
    assign ctl_pcValue_mux     = pcm_q;
    assign ctl_aluSrc1_mux     = src1_q;
    assign ctl_aluSrc2_mux     = src2_q;
    assign ctl_alu_mux         = alu_q;
    assign ctl_rfWriteData_mux = wd_q;
    assign ctl_rfWriteAddr_mux = wa_q;
    assign ctl_rf_wen          = rf_wen_q;
    assign ctl_dataRam_en      = ram_en_q;
    assign ctl_dataRam_wen     = ram_wen_q;
    assign ctl_low_wen         = lo_wen_q;
    assign ctl_high_wen        = hi_wen_q;
    assign ctl_temp_wen        = temp_wen_q;
    assign stall_count         = sc_q;
endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: decode table sweep plus interlock, backpressure,
// flush and asynchronous reset sequences.
module tb_id_decode_stage;
    logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_inst = '0, in_pc = '0;

    logic        in_ready, out_valid, rf_wen, ram_en, ram_wen, lo_wen, hi_wen, temp_wen, hilo_busy;
    logic [31:0] out_pc, stall_count;
    logic [4:0]  out_rs, out_rt, out_rd, out_sa, pcm;
    logic [15:0] out_imm;
    logic [25:0] out_idx;
    logic [2:0]  src1, wd, wa;
    logic [3:0]  src2;
    logic [19:0] alu;

    logic        nf_in_ready, nf_out_valid, nf_b0, nf_b1, nf_b2, nf_b3, nf_b4, nf_b5, nf_busy;
    logic [31:0] nf_out_pc, nf_stall_count;
    logic [4:0]  nf_rs, nf_rt, nf_rd, nf_sa, nf_pcm;
    logic [15:0] nf_imm;
    logic [25:0] nf_idx;
    logic [2:0]  nf_src1, nf_wd, nf_wa;
    logic [3:0]  nf_src2;
    logic [19:0] nf_alu;

    id_decode_stage #(.ALU_OPS(20), .MUL_LAT(4), .DIV_LAT(33), .LU_STALL_EN(1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_ready(out_ready), .out_valid(out_valid),
        .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_sa(out_sa),
        .out_imm(out_imm), .out_instIndex(out_idx), .ctl_pcValue_mux(pcm),
        .ctl_aluSrc1_mux(src1), .ctl_aluSrc2_mux(src2), .ctl_alu_mux(alu),
        .ctl_rfWriteData_mux(wd), .ctl_rfWriteAddr_mux(wa), .ctl_rf_wen(rf_wen),
        .ctl_dataRam_en(ram_en), .ctl_dataRam_wen(ram_wen), .ctl_low_wen(lo_wen),
        .ctl_high_wen(hi_wen), .ctl_temp_wen(temp_wen), .hilo_busy(hilo_busy),
        .stall_count(stall_count)
    );

    id_decode_stage #(.ALU_OPS(20), .MUL_LAT(4), .DIV_LAT(33), .LU_STALL_EN(0)) dut_nf (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(nf_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_ready(out_ready), .out_valid(nf_out_valid),
        .out_pc(nf_out_pc), .out_rs(nf_rs), .out_rt(nf_rt), .out_rd(nf_rd), .out_sa(nf_sa),
        .out_imm(nf_imm), .out_instIndex(nf_idx), .ctl_pcValue_mux(nf_pcm),
        .ctl_aluSrc1_mux(nf_src1), .ctl_aluSrc2_mux(nf_src2), .ctl_alu_mux(nf_alu),
        .ctl_rfWriteData_mux(nf_wd), .ctl_rfWriteAddr_mux(nf_wa), .ctl_rf_wen(nf_b0),
        .ctl_dataRam_en(nf_b1), .ctl_dataRam_wen(nf_b2), .ctl_low_wen(nf_b3),
        .ctl_high_wen(nf_b4), .ctl_temp_wen(nf_b5), .hilo_busy(nf_busy),
        .stall_count(nf_stall_count)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [19:0] alu;
        logic [3:0]  src2;
        logic [2:0]  wd;
        logic        wen;
    } vec_t;

    // Expected entry: {pc, inst, alu, src2, wd, wen}
    logic [91:0] exp_q[$];
    logic [91:0] mon_e;
    logic [31:0] mon_i;
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input int b, input logic [3:0] s2,
                                input logic [2:0] w, input logic en);
        vec_t r;
        r.inst = inst; r.alu = '0; r.src2 = s2; r.wd = w; r.wen = en;
        if (b >= 0) r.alu[b] = 1'b1;
        return r;
    endfunction

    // Scoreboard: pop and compare whenever EX takes the output register.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                mon_i = mon_e[59:28];
                check("out_pc", 64'(out_pc), 64'(mon_e[91:60]));
                check("out_rs", 64'(out_rs), 64'(mon_i[25:21]));
                check("out_rt", 64'(out_rt), 64'(mon_i[20:16]));
                check("out_rd", 64'(out_rd), 64'(mon_i[15:11]));
                check("out_sa", 64'(out_sa), 64'(mon_i[10:6]));
                check("out_imm", 64'(out_imm), 64'(mon_i[15:0]));
                check("out_idx", 64'(out_idx), 64'(mon_i[25:0]));
                check("ctl_alu_mux", 64'(alu), 64'(mon_e[27:8]));
                check("ctl_aluSrc2", 64'(src2), 64'(mon_e[7:4]));
                check("ctl_rfWData", 64'(wd), 64'(mon_e[3:1]));
                check("ctl_rf_wen", 64'(rf_wen), 64'(mon_e[0]));
            end
        end
    end

    // Driver: present one instruction until accepted; returns stall cycles seen.
    task automatic send(input vec_t v, input logic [31:0] pc, output int stalls);
        bit acc = 1'b0;
        in_inst = v.inst; in_pc = pc; in_valid = 1'b1; stalls = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin acc = 1'b1; break; end
            stalls++;
            @(posedge clk); #1;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
        else exp_q.push_back({pc, v.inst, v.alu, v.src2, v.wd, v.wen});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !hilo_busy && !out_valid) begin done = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!done) check("drain_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    vec_t vt[$];
    vec_t v_lw, v_add, v_or, v_xor, v_nor, v_mult, v_div, v_mflo;

    task automatic hl_test(input string nm, input vec_t opv, input int lat);
        int st, st2, busy;
        logic [31:0] sc0;
        drain();
        sc0 = stall_count;
        send(opv, 32'h2000, st);
        busy = 0;
        fork
            begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    if (!hilo_busy) break;
                    busy++;
                end
            end
            begin
                @(posedge clk); #1;
                send(v_mflo, 32'h2004, st2);
            end
        join
        check({nm, "_busy_cycles"}, 64'(busy), 64'(lat));
        check({nm, "_mflo_stalls"}, 64'(st2), 64'(lat - 1));
        check({nm, "_stall_count"}, 64'(stall_count - sc0), 64'(lat - 1));
    endtask

    initial begin
        int st;
        logic [31:0] sc0, nsc0;
        v_add  = mk(32'h00431020, 0, 4'h1, 3'h1, 1'b1);
        v_lw   = mk(32'h8C220004, 0, 4'h2, 3'h2, 1'b1);
        v_or   = mk(32'h00430825, 5, 4'h1, 3'h1, 1'b1);
        v_xor  = mk(32'h00430826, 6, 4'h1, 3'h1, 1'b1);
        v_nor  = mk(32'h00430827, 7, 4'h1, 3'h1, 1'b1);
        v_mult = mk(32'h00430018, 12, 4'h1, 3'h0, 1'b0);
        v_div  = mk(32'h0043001A, 14, 4'h1, 3'h0, 1'b0);
        v_mflo = mk(32'h00001012, -1, 4'h8, 3'h1, 1'b1);
        vt.push_back(v_add);
        vt.push_back(mk(32'h00431022, 1, 4'h1, 3'h1, 1'b1));
        vt.push_back(mk(32'h0043102A, 2, 4'h1, 3'h1, 1'b1));
        vt.push_back(mk(32'h0043102B, 3, 4'h1, 3'h1, 1'b1));
        vt.push_back(mk(32'h00430824, 4, 4'h1, 3'h1, 1'b1));
        vt.push_back(v_or);
        vt.push_back(v_xor);
        vt.push_back(v_nor);
        vt.push_back(mk(32'h00030900, 8, 4'h1, 3'h1, 1'b1));
        vt.push_back(mk(32'h00030902, 9, 4'h1, 3'h1, 1'b1));
        vt.push_back(mk(32'h00030903, 10, 4'h1, 3'h1, 1'b1));
        vt.push_back(mk(32'h3C011234, 11, 4'h4, 3'h1, 1'b1));
        vt.push_back(mk(32'h20220005, 0, 4'h2, 3'h1, 1'b1));
        vt.push_back(mk(32'h3022000F, 4, 4'h4, 3'h1, 1'b1));
        vt.push_back(v_lw);
        vt.push_back(mk(32'hAC220008, 0, 4'h2, 3'h0, 1'b0));
        vt.push_back(mk(32'h10430003, 1, 4'h1, 3'h0, 1'b0));
        vt.push_back(mk(32'h00001010, -1, 4'h8, 3'h1, 1'b1));
        vt.push_back(mk(32'h00430019, 13, 4'h1, 3'h0, 1'b0));
        vt.push_back(mk(32'h0043001B, 15, 4'h1, 3'h0, 1'b0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_alu", 64'(alu), 64'(0));
        check("rst_stall_count", 64'(stall_count), 64'(0));
        check("rst_hilo_busy", 64'(hilo_busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        resetn = 1'b1;

        // Decode sweep
        foreach (vt[i]) send(vt[i], 32'h1000 + 32'(i * 4), st);
        drain();

        // Load-use: one bubble; the non-interlocked instance takes add at once
        sc0 = stall_count; nsc0 = nf_stall_count;
        send(v_lw, 32'h1800, st);
        in_inst = v_add.inst; in_pc = 32'h1804; in_valid = 1'b1;
        @(negedge clk);
        check("lu_in_ready_stalled", 64'(in_ready), 64'(0));
        check("lu_nf_in_ready", 64'(nf_in_ready), 64'(1));
        @(posedge clk); #1;
        check("lu_bubble", 64'(out_valid), 64'(0));
        check("lu_nf_no_bubble", 64'(nf_out_valid), 64'(1));
        check("lu_nf_alu", 64'(nf_alu), 64'(20'h1));
        @(negedge clk);
        check("lu_in_ready_after", 64'(in_ready), 64'(1));
        exp_q.push_back({32'h1804, v_add.inst, v_add.alu, v_add.src2, v_add.wd, v_add.wen});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lu_add_valid", 64'(out_valid), 64'(1));
        check("lu_add_alu", 64'(alu), 64'(20'h1));
        check("lu_stall_count", 64'(stall_count - sc0), 64'(1));
        check("lu_nf_stall_count", 64'(nf_stall_count - nsc0), 64'(0));

        // HI/LO interlocks
        hl_test("mult", v_mult, 4);
        hl_test("div", v_div, 33);

        // Backpressure
        drain();
        sc0 = stall_count;
        out_ready = 1'b0;
        send(v_add, 32'h3000, st);
        in_inst = v_or.inst; in_pc = 32'h3004; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_out_pc", 64'(out_pc), 64'(32'h3000));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_first", 64'(in_ready), 64'(1));
        exp_q.push_back({32'h3004, v_or.inst, v_or.alu, v_or.src2, v_or.wd, v_or.wen});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_no_stall_count", 64'(stall_count - sc0), 64'(0));

        // Flush: held output killed, incoming instruction dropped
        drain();
        out_ready = 1'b0;
        send(v_xor, 32'h4000, st);
        in_inst = v_nor.inst; in_pc = 32'h4004; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready", 64'(in_ready), 64'(1));
        check("fl_out_valid_before", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid_after", 64'(out_valid), 64'(0));
        check("fl_queue_depth", 64'(exp_q.size()), 64'(1));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fl_dropped", 64'(out_valid), 64'(0));

        // Asynchronous reset mid-stream
        drain();
        out_ready = 1'b0;
        send(v_div, 32'h5000, st);
        repeat (13) @(posedge clk);
        #1;
        check("ar_pre_valid", 64'(out_valid), 64'(1));
        check("ar_pre_busy", 64'(hilo_busy), 64'(1));
        #2;
        resetn = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'(0));
        check("ar_hilo_busy", 64'(hilo_busy), 64'(0));
        check("ar_alu", 64'(alu), 64'(0));
        check("ar_wens", 64'({rf_wen, ram_en, ram_wen, lo_wen, hi_wen, temp_wen}), 64'(0));
        check("ar_groups", 64'({pcm, src1, src2, wd, wa}), 64'(0));
        check("ar_out_pc", 64'(out_pc), 64'(0));
        check("ar_stall_count", 64'(stall_count), 64'(0));
        exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered MIPS instruction-decode stage with a valid/ready handshake on both sides.
- Decodes via the existing id_control one-hot groups, with the ALU op group widened to ALU_OPS bits and populated for the logic, shift, mult and div ops.
- Adds stall generation for load-use hazards and for HI/LO access while a multi-cycle mult/div is in flight. Supports flush from a taken branch or redirect.
- Sits between the IF output and the EX input register.

Parameters:
- ALU_OPS, 20, width of ctl_alu_mux (minimum 16).
- MUL_LAT, 4, cycles the HI/LO unit stays busy after a MULT/MULTU issues (1..15).
- DIV_LAT, 33, cycles the HI/LO unit stays busy after a DIV/DIVU issues (1..63).
- LU_STALL_EN, 1, 1 enables the load-use interlock; 0 disables it (forwarding handled elsewhere).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction in the output register and drop the incoming one
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_inst  in  32  instruction word
- in_pc  in  32  PC of in_inst
- out_ready  in  1  EX accepts the output
- out_valid  out  1  output register holds a live instruction
- out_pc  out  32  registered PC
- out_rs, out_rt, out_rd, out_sa  out  5 each  registered fields
- out_imm  out  16  inst[15:0]
- out_instIndex  out  26  inst[25:0]
- ctl_pcValue_mux  out  5; ctl_aluSrc1_mux  out  3; ctl_aluSrc2_mux  out  4; ctl_alu_mux  out  ALU_OPS; ctl_rfWriteData_mux  out  3; ctl_rfWriteAddr_mux  out  3  one-hot groups, registered
- ctl_rf_wen, ctl_dataRam_en, ctl_dataRam_wen, ctl_low_wen, ctl_high_wen, ctl_temp_wen  out  1 each  registered
- hilo_busy  out  1  HI/LO countdown nonzero
- stall_count  out  32  saturating count of stall cycles

Behaviour:
- Reset: out_valid=0, every registered field and ctl output=0, hilo counter=0, stall_count=0. Reset is asynchronous and may assert mid-operation; the in-flight instruction and the counter are lost.
- ALU group bit map:
  - 0 add, 1 sub, 2 slt, 3 sltu: existing decode.
  - 4 and/andi, 5 or/ori, 6 xor/xori, 7 nor.
  - 8 sll/sllv, 9 srl/srlv, 10 sra/srav, 11 lui.
  - 12 mult, 13 multu, 14 div, 15 divu.
  - Bits ≥16 tie to 0.
  - At most one bit is set per instruction.
- Handshake:
  - load = ~out_valid | out_ready.
  - in_ready = load & ~stall, or 1 when flush=1.
  - On a clk edge with load=1: out_valid <= in_valid & ~stall & ~flush; fields and ctl capture the decode of in_inst.
  - With load=0 all outputs hold.
- Flush: on the edge, out_valid <= 0 and the incoming instruction is dropped. The hilo counter is not cleared (conservative).
- stall = lu_hz | hl_hz.
  - lu_hz (only when LU_STALL_EN=1) requires all of:
    - out_valid=1;
    - output instruction is a load (ctl_rfWriteData_mux[1]=1);
    - out_rt != 0;
    - out_rt equals in_inst rs, or equals in_inst rt when the incoming instruction reads rt (aluSrc2 rt, store, BEQ/BNE).
  - lu_hz therefore yields exactly one bubble when EX is always ready.
  - hl_hz = hilo_busy and the incoming instruction is MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV or DIVU.
  - stall is evaluated only when in_valid=1; no stall while in_valid=0.
- HI/LO counter:
  - On the handshake edge of a MULT/MULTU it loads MUL_LAT.
  - On the handshake edge of a DIV/DIVU it loads DIV_LAT.
  - Otherwise it decrements if nonzero and holds at 0.
  - A load takes priority over a decrement on the same edge.
  - Width = ceil(log2(max(MUL_LAT, DIV_LAT)+1)).
- stall_count increments on each edge where in_valid & stall & ~flush; it saturates at 0xFFFFFFFF.
- The $zero write quirk is preserved: ctl_rf_wen may be 1 for rd=0.

Test Plan:
- Reset mid-stream: assert resetn=0 with out_valid=1 and counter=20 -> out_valid=0, hilo_busy=0 and all ctl outputs 0 immediately, with no clk edge required.
- Load-use: issue 0x8C220004 (lw $2,4($1)), then 0x00431020 (add $2,$2,$3), with out_ready=1 -> exactly one bubble cycle (out_valid=0); add appears with ctl_alu_mux[0]=1; stall_count=1. With LU_STALL_EN=0 -> no bubble.
- HI/LO interlock: MUL_LAT=4, issue 0x00430018 (mult) then 0x00001012 (mflo $2) -> mflo leaves 4 cycles after mult with ctl_aluSrc2_mux[3]=1; hilo_busy is high for 4 cycles; stall_count=3. Repeat with 0x0043001A (div), DIV_LAT=33 -> 32 stall cycles.
- Backpressure: out_ready=0 for 5 cycles with a valid instruction held -> in_ready=0 and outputs stable; the next instruction is accepted the first cycle out_ready=1.
- Flush: flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and in_ready=1 during flush; the incoming instruction never appears at the output.
- Decode sweep: and/or/xor/nor/sll/srl/sra/lui/multu/divu encodings -> ctl_alu_mux one-hot at bits 4,5,6,7,8,9,10,11,13,15 respectively, and bits 16..19 = 0.
